// File: rtl/imem_access_ctrl.sv
// Fetch/load sequencer and arbiter for the nibble-wide instruction memory port.
// Optional readback verify of loads: define IMEM_LOAD_VERIFY_EN.
module imem_access_ctrl #(
  parameter int unsigned WORD_LEN = 16,
  parameter int unsigned CELL_LEN = 4,
  parameter int unsigned MEM_SIZE = 1024,
  localparam int unsigned ADDR_W  = $clog2(MEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ack,
  output logic                fetch_valid,
  output logic [WORD_LEN-1:0] fetch_instr,
  input  logic                load_req,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [WORD_LEN-1:0] load_data,
  output logic                load_ack,
  output logic                load_done,
  output logic                load_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [CELL_LEN-1:0] mem_wdata,
  input  logic [CELL_LEN-1:0] mem_rdata
);

  localparam int unsigned BEATS  = WORD_LEN / CELL_LEN;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD
`ifdef IMEM_LOAD_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic                last_grant_q;  // 1: load was granted last
  logic [ADDR_W-1:0]   base_q;
  logic [WORD_LEN-1:0] data_q;        // rotates one nibble per beat, MSB nibble on top
  logic [WORD_LEN-1:0] asm_q;
  logic                grant_fetch, grant_load;
  logic                last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and arbitration; a tie goes to whoever was not granted last
  always_comb begin
    state_d     = state_q;
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_req && (!load_req || last_grant_q)) begin
          grant_fetch = 1'b1;
          state_d     = S_FETCH;
        end else if (load_req) begin
          grant_load = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_FETCH: if (last_beat) state_d = S_IDLE;
`ifdef IMEM_LOAD_VERIFY_EN
      S_LOAD:   if (last_beat) state_d = S_VERIFY;
      S_VERIFY: if (last_beat) state_d = S_IDLE;
`else
      S_LOAD:   if (last_beat) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Acks and memory port decode; a reset cycle neither acks nor writes
  always_comb begin
    fetch_ack = grant_fetch & ~rst;
    load_ack  = grant_load & ~rst;
    busy      = (state_q != S_IDLE);
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q != S_IDLE) mem_addr = base_q + ADDR_W'(beat_q);
    if (state_q == S_LOAD) begin
      mem_we    = ~rst;
      mem_wdata = data_q[WORD_LEN-1 -: CELL_LEN];
    end
  end

`ifdef IMEM_LOAD_VERIFY_EN
  logic mism_q;
  logic nib_miss;
  assign nib_miss = (mem_rdata != data_q[WORD_LEN-1 -: CELL_LEN]);
`else
  assign load_err = 1'b0;
`endif

  // Beat counter, latched request, word assembly and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q       <= '0;
      last_grant_q <= 1'b1;
      base_q       <= '0;
      data_q       <= '0;
      asm_q        <= '0;
      fetch_instr  <= '0;
      fetch_valid  <= 1'b0;
      load_done    <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
      load_err     <= 1'b0;
      mism_q       <= 1'b0;
`endif
    end else begin
      fetch_valid <= 1'b0;
      load_done   <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
      load_err    <= 1'b0;
`endif
      if (grant_fetch) begin
        base_q       <= fetch_addr;
        beat_q       <= '0;
        last_grant_q <= 1'b0;
      end
      if (grant_load) begin
        base_q       <= load_addr;
        data_q       <= load_data;
        beat_q       <= '0;
        last_grant_q <= 1'b1;
`ifdef IMEM_LOAD_VERIFY_EN
        mism_q       <= 1'b0;
`endif
      end
      case (state_q)
        S_FETCH: begin
          asm_q  <= {asm_q[WORD_LEN-CELL_LEN-1:0], mem_rdata};
          beat_q <= BEAT_W'(beat_q + 1'b1);
          if (last_beat) begin
            fetch_instr <= {asm_q[WORD_LEN-CELL_LEN-1:0], mem_rdata};
            fetch_valid <= 1'b1;
          end
        end
        S_LOAD: begin
          data_q <= {data_q[WORD_LEN-CELL_LEN-1:0], data_q[WORD_LEN-1 -: CELL_LEN]};
          beat_q <= BEAT_W'(beat_q + 1'b1);
`ifndef IMEM_LOAD_VERIFY_EN
          if (last_beat) load_done <= 1'b1;
`endif
        end
`ifdef IMEM_LOAD_VERIFY_EN
        S_VERIFY: begin
          data_q <= {data_q[WORD_LEN-CELL_LEN-1:0], data_q[WORD_LEN-1 -: CELL_LEN]};
          beat_q <= BEAT_W'(beat_q + 1'b1);
          mism_q <= mism_q | nib_miss;
          if (last_beat) begin
            load_done <= 1'b1;
            load_err  <= mism_q | nib_miss;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: stimulus pushes expectations, a negedge monitor pops them.
module tb_imem_access_ctrl;

`ifdef IMEM_LOAD_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
  localparam int LAT_DONE  = 9;
`else
  localparam bit VERIFY_ON = 1'b0;
  localparam int LAT_DONE  = 5;
`endif
  localparam int LAT_VALID = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [9:0]  fetch_addr = '0;
  logic        fetch_ack, fetch_valid;
  logic [15:0] fetch_instr;
  logic        load_req = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_ack, load_done, load_err, busy;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata, mem_rdata;

  imem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .load_done(load_done), .load_err(load_err),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model with backdoor write port and optional stuck-at-0 read on cell 22
  logic [3:0] mem [0:1023];
  logic       mem_clr = 1'b1;
  logic       bk_we = 1'b0;
  logic [9:0] bk_addr = '0;
  logic [3:0] bk_data = '0;
  bit         stuck = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (bk_we) begin
      mem[bk_addr] <= bk_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (stuck && mem_addr == 10'd22) ? 4'h0 : mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] addr;
    logic       we;
    logic [3:0] wdata;
  } beat_t;

  beat_t       exp_beat[$];
  bit          exp_ack[$];     // 0 fetch, 1 load
  logic [15:0] exp_instr[$];
  bit          exp_err[$];
  int          fa_cyc[$], la_cyc[$];
  int          last_lack = -1, last_fvalid = -2;
  int          n_vec = 0, n_miss = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_fetch(input logic [9:0] a, input logic [15:0] instr);
    beat_t b;
    exp_ack.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      b.addr = 10'(a + 10'(i)); b.we = 1'b0; b.wdata = '0;
      exp_beat.push_back(b);
    end
    exp_instr.push_back(instr);
  endfunction

  // nwr < 4 models a load aborted by reset: only the first nwr writes appear
  function automatic void push_load(input logic [9:0] a, input logic [15:0] d,
                                    input int nwr, input bit err);
    beat_t b;
    exp_ack.push_back(1'b1);
    for (int i = 0; i < nwr; i++) begin
      b.addr = 10'(a + 10'(i)); b.we = 1'b1; b.wdata = d[15-4*i -: 4];
      exp_beat.push_back(b);
    end
    if (nwr == 4) begin
      if (VERIFY_ON) begin
        for (int i = 0; i < 4; i++) begin
          b.addr = 10'(a + 10'(i)); b.we = 1'b0; b.wdata = '0;
          exp_beat.push_back(b);
        end
      end
      exp_err.push_back(err);
    end
  endfunction

  // Monitor: every cycle out of reset is checked against the expectation queues
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      fa_cyc.delete();
      la_cyc.delete();
    end else begin
      if (fetch_ack || load_ack) begin
        check("ack_expected", 32'(exp_ack.size() != 0), 1);
        if (exp_ack.size() != 0)
          check("ack_who", {fetch_ack, load_ack}, exp_ack.pop_front() ? 2'b01 : 2'b10);
        if (fetch_ack) fa_cyc.push_back(cyc);
        if (load_ack) begin la_cyc.push_back(cyc); last_lack = cyc; end
      end
      if (busy) begin
        check("beat_expected", 32'(exp_beat.size() != 0), 1);
        if (exp_beat.size() != 0) begin
          b = exp_beat.pop_front();
          check("beat_addr", mem_addr, b.addr);
          check("beat_we", mem_we, b.we);
          if (b.we) check("beat_wdata", mem_wdata, b.wdata);
        end
      end else begin
        check("idle_port", {mem_we, mem_addr}, 0);
      end
      if (fetch_valid) begin
        last_fvalid = cyc;
        check("valid_expected", 32'(exp_instr.size() != 0), 1);
        if (exp_instr.size() != 0) check("fetch_instr", fetch_instr, exp_instr.pop_front());
        check("valid_has_ack", 32'(fa_cyc.size() != 0), 1);
        if (fa_cyc.size() != 0) check("fetch_latency", cyc - fa_cyc.pop_front(), LAT_VALID);
      end
      if (load_done) begin
        check("done_expected", 32'(exp_err.size() != 0), 1);
        if (exp_err.size() != 0) check("load_err", load_err, exp_err.pop_front());
        check("done_has_ack", 32'(la_cyc.size() != 0), 1);
        if (la_cyc.size() != 0) check("load_latency", cyc - la_cyc.pop_front(), LAT_DONE);
      end else if (load_err) begin
        check("err_without_done", load_err, 0);
      end
    end
  end

  task automatic drv_fetch(input logic [9:0] a);
    bit got = 1'b0;
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = a;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = fetch_ack; end
    check("fetch_ack_seen", got, 1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic drv_load(input logic [9:0] a, input logic [15:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    load_req = 1'b1; load_addr = a; load_data = d;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = load_ack; end
    check("load_ack_seen", got, 1);
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic bk_write(input logic [9:0] a, input logic [3:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic wait_drain();
    int left;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      left = exp_beat.size() + exp_ack.size() + exp_instr.size() + exp_err.size();
      if (left == 0 && !busy) break;
    end
    check("drain", exp_beat.size() + exp_ack.size() + exp_instr.size() + exp_err.size() + 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_instr", fetch_instr, 0);
    check("rst_pulses", {fetch_ack, load_ack, fetch_valid, load_done, load_err}, 0);
    check("rst_port", {mem_we, mem_wdata, mem_addr}, 0);

    bk_write(10'd100, 4'h5); bk_write(10'd101, 4'h6);
    bk_write(10'd102, 4'h7); bk_write(10'd103, 4'h8);

    // First tie after reset: fetch wins, load accepted in the fetch_valid cycle
    push_fetch(10'd100, 16'h5678);
    push_load(10'd200, 16'hBEEF, 4, 1'b0);
    fork drv_fetch(10'd100); drv_load(10'd200, 16'hBEEF); join
    wait_drain();
    check("b2b_accept", last_lack, last_fvalid);

    // Load was granted last, so the next tie goes to fetch again
    push_fetch(10'd200, 16'hBEEF);
    push_load(10'd300, 16'h1357, 4, 1'b0);
    fork drv_fetch(10'd200); drv_load(10'd300, 16'h1357); join
    wait_drain();

    push_fetch(10'd300, 16'h1357);
    drv_fetch(10'd300);
    wait_drain();

    // Fetch was granted last: a tie now favours load
    push_load(10'd400, 16'h2468, 4, 1'b0);
    push_fetch(10'd400, 16'h2468);
    fork drv_fetch(10'd400); drv_load(10'd400, 16'h2468); join
    wait_drain();

    push_load(10'd8, 16'h310A, 4, 1'b0);
    drv_load(10'd8, 16'h310A);
    wait_drain();
    push_fetch(10'd8, 16'h310A);
    drv_fetch(10'd8);
    wait_drain();

    // Address wrap at the top of memory
    bk_write(10'd1022, 4'h1); bk_write(10'd1023, 4'h2);
    bk_write(10'd0, 4'h3);    bk_write(10'd1, 4'h4);
    push_fetch(10'd1022, 16'h1234);
    drv_fetch(10'd1022);
    wait_drain();

    // Reset during beat 2 of a load
    push_load(10'd20, 16'hFFFF, 2, 1'b0);
    drv_load(10'd20, 16'hFFFF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_we", mem_we, 0);
    check("abort_instr", fetch_instr, 0);
    check("abort_cells", {mem[20], mem[21], mem[22], mem[23]}, 16'hFF00);
    wait_drain();

    push_load(10'd24, 16'hA5C3, 4, 1'b0);
    drv_load(10'd24, 16'hA5C3);
    wait_drain();
    push_fetch(10'd24, 16'hA5C3);
    drv_fetch(10'd24);
    wait_drain();

    // Readback with cell 22 stuck at 0, then without the fault
    stuck = 1'b1;
    push_load(10'd20, 16'h1111, 4, VERIFY_ON);
    drv_load(10'd20, 16'h1111);
    wait_drain();
    stuck = 1'b0;
    push_load(10'd20, 16'h1111, 4, 1'b0);
    drv_load(10'd20, 16'h1111);
    wait_drain();
    push_fetch(10'd20, 16'h1111);
    drv_fetch(10'd20);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequencer and arbiter for the nibble-wide single-port instruction memory (4-bit cells, 16-bit instructions stored MSB-nibble first at addr..addr+3).
- Shares the port between the IF-stage fetch requester (read) and the program loader (write).
- Each transaction is a 4-beat nibble burst; fetches are assembled into a 16-bit word and loads are split into nibbles.
- Sits between the IF stage, the loader, and the memory array.

Parameters:
- WORD_LEN, 16, instruction width
- CELL_LEN, 4, memory cell width; BEATS = WORD_LEN/CELL_LEN = 4, fixed
- MEM_SIZE, 1024, cells in memory; ADDR_W = $clog2(MEM_SIZE)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  fetch request, level; held until fetch_ack
- fetch_addr  in  ADDR_W  fetch base address, sampled at accept
- fetch_ack  out  1  one-cycle pulse: fetch accepted
- fetch_valid  out  1  one-cycle pulse: fetch_instr valid
- fetch_instr  out  WORD_LEN  assembled instruction
- load_req  in  1  load request, level; held until load_ack
- load_addr  in  ADDR_W  load base address, sampled at accept
- load_data  in  WORD_LEN  word to write, sampled at accept
- load_ack  out  1  one-cycle pulse: load accepted
- load_done  out  1  one-cycle pulse: load complete
- load_err  out  1  readback mismatch pulse (see Optional Feature)
- busy  out  1  high while not IDLE
- mem_addr  out  ADDR_W  memory cell address
- mem_we  out  1  memory write enable
- mem_wdata  out  CELL_LEN  write nibble
- mem_rdata  in  CELL_LEN  read nibble, combinational from mem_addr

Behaviour:
- States: IDLE, FETCH, LOAD (plus VERIFY with the macro). Beat counter 0..3. Register last_grant.
- Reset (synchronous): state IDLE, beat 0, last_grant=LOAD (fetch wins the first tie), fetch_instr 0. All pulses, busy, mem_we and load_err 0; mem_addr 0; mem_wdata 0.
- Reset mid-transaction aborts it. No valid/done pulse is issued; cells already written stay written.
- Arbitration is evaluated only in IDLE:
  - Single requester: it is granted.
  - Both requesting: grant the one not equal to last_grant.
  - No preemption of an active burst.
  - Deasserting req before its ack withdraws the request.
- Accept cycle T (IDLE, grant):
  - Ack pulse, latch base address (and load_data), set last_grant, next state FETCH or LOAD.
- Beats at T+1..T+4:
  - mem_addr = (base + beat) mod MEM_SIZE; wrap-around allowed; no alignment check.
- FETCH beat:
  - Shift mem_rdata into the assembly register, MSB nibble first (beat 0 -> bits 15:12).
- LOAD beat:
  - mem_we=1, mem_wdata = load_data nibble [15-4*beat -: 4].
- After beat 3: return to IDLE.
  - At T+5, fetch_valid or load_done pulses for one cycle.
  - fetch_instr holds its value until the next fetch completes.
- Latency:
  - Request to ack is 0 cycles when IDLE and granted.
  - Ack to valid/done is 5 cycles.
- A new accept may occur in the same IDLE cycle as a valid/done pulse, giving back-to-back throughput of 1 word per 5 cycles.
- mem_we, mem_addr and mem_wdata are decoded combinationally from registered state/beat/base. mem_we is never high outside LOAD.
- In IDLE: mem_addr = 0, mem_we = 0.

Optional Feature:
- Macro IMEM_LOAD_VERIFY_EN.
- Defined:
  - After LOAD beat 3, enter VERIFY: 4 read beats of the same addresses, comparing mem_rdata against the written nibbles.
  - load_done pulses at T+9.
  - load_err pulses in the same cycle if any nibble mismatched.
  - Reset during VERIFY aborts with no pulses.
- Undefined:
  - No VERIFY state; load_done at T+5; load_err tied 0.

Test Plan:
- Load load_addr=8, load_data=0x310A:
  - load_ack at T.
  - mem writes 3,1,0,A to cells 8..11 at T+1..T+4.
  - load_done at T+5.
- After that load, fetch fetch_addr=8:
  - mem_addr 8,9,10,11 read.
  - fetch_valid at T+5 with fetch_instr=0x310A.
- Right after reset, fetch_req and load_req rise in the same cycle:
  - fetch granted first.
  - load acked in the IDLE cycle of fetch_valid.
  - Next tie goes to fetch again, alternating.
- MEM_SIZE=1024, fetch_addr=1022:
  - mem_addr sequence 1022,1023,0,1.
  - Cells hold 1,2,3,4, so fetch_instr=0x1234.
- Load 0xFFFF at 20, with rst asserted at beat 2:
  - Only cells 20,21 written.
  - No load_done; busy=0 and mem_we=0 after the reset edge.
  - Next request accepted normally.
- With IMEM_LOAD_VERIFY_EN, memory model forces cell 22 stuck at 0; load 0x1111 at 20:
  - load_done and load_err both pulse at T+9.
  - Without the fault, load_err stays 0.
